// File: rtl/uart_fifo_bridge_if.sv
// Bus bundle for uart_fifo_bridge: 68k-side register port plus the uart register port.
// "slave" is the bridge's view; "master" is the environment (CPU decoder and uart).
interface uart_fifo_bridge_if;
  logic        cs;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        ack;
  logic        irq;

  logic [7:0]  u_addr;
  logic        u_uds;
  logic        u_lds;
  logic        u_rw;
  logic [15:0] u_data_write;
  logic [15:0] u_data_read;
  logic        u_ack;
  logic        u_tx_active;
  logic        u_rx_avail;
  logic        u_rx_avail_clear;

  modport slave (
    input  cs, addr, uds, lds, rw, data_write,
    output data_read, ack, irq,
    output u_addr, u_uds, u_lds, u_rw, u_data_write, u_rx_avail_clear,
    input  u_data_read, u_ack, u_tx_active, u_rx_avail
  );

  modport master (
    output cs, addr, uds, lds, rw, data_write,
    input  data_read, ack, irq,
    input  u_addr, u_uds, u_lds, u_rw, u_data_write, u_rx_avail_clear,
    output u_data_read, u_ack, u_tx_active, u_rx_avail
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffered CPU<->uart bridge: RX/TX byte FIFOs plus a 3-clk ISSUE/ACK/GAP uart access engine.
// Optional feature macro UART_FIFO_OVERRUN_EN: discard bytes arriving while RX is full and flag ovr.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic               clk,
  input logic               reset,
  uart_fifo_bridge_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_GAP} state_t;

  state_t        r_state;
  logic          r_op_rx;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [AW:0]   r_rx_count, r_tx_count;
  logic          r_sel_q, r_ack, r_irq, r_ovr;
  logic [15:0]   r_data_read;
  logic [7:0]    r_u_addr;
  logic          r_u_uds, r_u_rw;
  logic [15:0]   r_u_data_write;
`ifdef UART_FIFO_OVERRUN_EN
  logic          r_u_rx_avail_clear;
`endif

  logic          w_sel, w_start, w_reg0, w_reg1;
  logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_stat_rd, w_ovr_set;
  logic [AW:0]   w_rx_count_next, w_tx_count_next;
  logic [7:0]    w_rx_head, w_tx_head, w_status, w_rx_count8, w_tx_count8;
  logic          w_unused_bits;

  assign w_sel      = bus.cs & (bus.uds | bus.lds);
  assign w_start    = w_sel & ~r_sel_q;
  assign w_reg0     = (bus.addr[7:1] == 7'd0);
  assign w_reg1     = (bus.addr[7:1] == 7'd1);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == (AW+1)'(DEPTH));
  assign w_tx_full  = (r_tx_count == (AW+1)'(DEPTH));
  assign w_rx_head  = r_rx_mem[r_rx_rp];
  assign w_tx_head  = r_tx_mem[r_tx_rp];

  // CPU pops RX / pushes TX; the engine pushes RX / pops TX. Full/empty gate each side.
  assign w_rx_pop   = w_start & w_reg0 & bus.rw & bus.uds & ~w_rx_empty;
  assign w_tx_push  = w_start & w_reg0 & ~bus.rw & bus.uds & ~w_tx_full;
  assign w_rx_push  = (r_state == S_ACK) & r_op_rx & bus.u_ack & ~w_rx_full;
  assign w_tx_pop   = (r_state == S_ACK) & ~r_op_rx & bus.u_ack & ~w_tx_empty;
  assign w_stat_rd  = w_start & w_reg0 & bus.rw & bus.lds;

  assign w_rx_count_next = r_rx_count + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
  assign w_tx_count_next = r_tx_count + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
  assign w_rx_count8     = 8'(r_rx_count);
  assign w_tx_count8     = 8'(r_tx_count);
  assign w_status        = {4'b0, r_ovr, w_tx_empty & ~bus.u_tx_active, w_tx_full, ~w_rx_empty};

`ifdef UART_FIFO_OVERRUN_EN
  assign w_ovr_set = (r_state == S_IDLE) & bus.u_rx_avail & w_rx_full;
`else
  assign w_ovr_set = 1'b0;
`endif

  assign w_unused_bits = ^{bus.addr[0], bus.data_write[7:0], bus.u_data_read[7:0]};

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.u_data_read[15:8];
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.data_write[15:8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_rx_count <= '0;
      r_tx_count <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      r_rx_count <= w_rx_count_next;
      r_tx_count <= w_tx_count_next;
      r_irq      <= (w_rx_count_next != '0);
    end
  end

  // CPU side: side effects only on the select edge; ack and data_read hold until cs drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_q     <= 1'b0;
      r_ack       <= 1'b0;
      r_data_read <= '0;
      r_ovr       <= 1'b0;
    end else begin
      r_sel_q <= w_sel;
      if (!bus.cs)
        r_ack <= 1'b0;
      else if (w_start & (w_reg0 | w_reg1))
        r_ack <= 1'b1;
      if (w_start & bus.rw) begin
        if (w_reg0)
          r_data_read <= {(bus.uds & ~w_rx_empty) ? w_rx_head : 8'h00,
                          bus.lds ? w_status : 8'h00};
        else if (w_reg1)
          r_data_read <= {w_rx_count8, w_tx_count8};
      end
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_stat_rd)
        r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op_rx        <= 1'b0;
      r_u_addr       <= 8'h02;
      r_u_uds        <= 1'b0;
      r_u_rw         <= 1'b1;
      r_u_data_write <= '0;
`ifdef UART_FIFO_OVERRUN_EN
      r_u_rx_avail_clear <= 1'b0;
`endif
    end else begin
`ifdef UART_FIFO_OVERRUN_EN
      r_u_rx_avail_clear <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.u_rx_avail & ~w_rx_full) begin
            r_op_rx  <= 1'b1;
            r_u_addr <= 8'h00;
            r_u_uds  <= 1'b1;
            r_u_rw   <= 1'b1;
            r_state  <= S_ISSUE;
          end
`ifdef UART_FIFO_OVERRUN_EN
          else if (w_ovr_set) begin
            r_u_rx_avail_clear <= 1'b1;
            r_state            <= S_GAP;
          end
`endif
          else if (~w_tx_empty & ~bus.u_tx_active) begin
            r_op_rx        <= 1'b0;
            r_u_addr       <= 8'h00;
            r_u_uds        <= 1'b1;
            r_u_rw         <= 1'b0;
            r_u_data_write <= {w_tx_head, 8'h00};
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_u_addr       <= 8'h02;
          r_u_uds        <= 1'b0;
          r_u_rw         <= 1'b1;
          r_u_data_write <= '0;
          r_state        <= S_ACK;
        end
        S_ACK:   r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_read    = r_data_read;
  assign bus.ack          = r_ack;
  assign bus.irq          = r_irq;
  assign bus.u_addr       = r_u_addr;
  assign bus.u_uds        = r_u_uds;
  assign bus.u_lds        = 1'b0;
  assign bus.u_rw         = r_u_rw;
  assign bus.u_data_write = r_u_data_write;
`ifdef UART_FIFO_OVERRUN_EN
  assign bus.u_rx_avail_clear = r_u_rx_avail_clear;
`else
  assign bus.u_rx_avail_clear = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed steps plus randomized bursts against a queue model.
module tb_uart_fifo_bridge;
  localparam int DEPTH = 16;
`ifdef UART_FIFO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_bridge_if bus();
  uart_fifo_bridge #(.DEPTH(16), .AW(4)) dut (.clk(clk), .reset(rst), .bus(bus));

  int n_cmp = 0, n_fail = 0;
  int n_dbl = 0, n_busy_wr = 0, n_lds = 0, n_clr = 0, n_clr_dbl = 0;
  logic [7:0] rxq[$];
  logic [7:0] tx_seen[$];
  logic [7:0] ops[$];
  logic tx_hold = 1'b0;
  int   busy_cnt = 0;
  logic prev_uds = 1'b0, prev_clr = 1'b0;

  // Behavioural uart: ack next clk, reads pop pending RX bytes, writes make the transmitter busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.u_ack       <= 1'b0;
      bus.u_data_read <= '0;
      bus.u_tx_active <= 1'b0;
      bus.u_rx_avail  <= 1'b0;
      busy_cnt        <= 0;
      prev_uds        <= 1'b0;
      prev_clr        <= 1'b0;
    end else begin
      bus.u_ack <= 1'b0;
      prev_uds  <= bus.u_uds;
      prev_clr  <= bus.u_rx_avail_clear;
      if (bus.u_uds && prev_uds) n_dbl <= n_dbl + 1;
      if (bus.u_lds) n_lds <= n_lds + 1;
      if (bus.u_uds && bus.u_addr == 8'h00) begin
        bus.u_ack <= 1'b1;
        if (bus.u_rw) begin
          ops.push_back(8'h52);
          if (rxq.size() > 0) bus.u_data_read <= {rxq.pop_front(), 8'h00};
        end else begin
          ops.push_back(8'h57);
          tx_seen.push_back(bus.u_data_write[15:8]);
          if (bus.u_tx_active) n_busy_wr <= n_busy_wr + 1;
        end
      end
      if (bus.u_rx_avail_clear) begin
        n_clr <= n_clr + 1;
        if (prev_clr) n_clr_dbl <= n_clr_dbl + 1;
        if (rxq.size() > 0) void'(rxq.pop_front());
      end
      if (bus.u_uds && bus.u_addr == 8'h00 && !bus.u_rw)
        busy_cnt <= int'($urandom_range(10, 3));
      else if (busy_cnt > 0)
        busy_cnt <= busy_cnt - 1;
      bus.u_tx_active <= tx_hold || (bus.u_uds && bus.u_addr == 8'h00 && !bus.u_rw) || (busy_cnt > 1);
      bus.u_rx_avail  <= (rxq.size() != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; one complete CPU cycle with bounded wait for ack.
  task automatic cpu_acc(input logic [7:0] a, input logic u, input logic l, input logic r,
                         input logic [15:0] wd, output logic [15:0] rd, output logic ok);
    bus.addr = a; bus.uds = u; bus.lds = l; bus.rw = r; bus.data_write = wd; bus.cs = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ack) begin ok = 1'b1; break; end
    end
    rd = bus.data_read;
    @(negedge clk);
    if (ok && r) check("rd_hold", bus.data_read, rd);
    bus.cs = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_counts(input string tag, input int rxc, input int txc);
    logic [15:0] d; logic ok; logic [7:0] r8, t8;
    r8 = rxc[7:0]; t8 = txc[7:0];
    cpu_acc(8'h02, 1'b1, 1'b1, 1'b1, 16'h0, d, ok);
    check(tag, {ok, d}, {1'b1, r8, t8});
  endtask

  task automatic chk_status(input string tag, input logic [7:0] exp);
    logic [15:0] d; logic ok;
    cpu_acc(8'h00, 1'b0, 1'b1, 1'b1, 16'h0, d, ok);
    check(tag, {ok, d}, {1'b1, 8'h00, exp});
  endtask

  task automatic wait_tx(input int n);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_seen.size() >= n && !bus.u_tx_active && !bus.u_uds) break;
    end
    check("tx_drain_in_time", (i < 3000), 1);
  endtask

  task automatic cpu_pop(input string tag, input logic [7:0] exp);
    logic [15:0] d; logic ok; int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.irq) break;
    end
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b1, 16'h0, d, ok);
    check(tag, {ok, d}, {1'b1, exp, 8'h00});
  endtask

  task automatic tx_burst(input int n);
    logic [7:0] exp_q[$]; logic [7:0] b; logic [15:0] d; logic ok; int acc;
    tx_hold = 1'b1;
    @(negedge clk);
    tx_seen.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, {b, 8'h00}, d, ok);
      check("tx_push_ack", ok, 1);
      if (i < DEPTH) exp_q.push_back(b);
    end
    acc = (n < DEPTH) ? n : DEPTH;
    chk_counts("tx_counts", 0, acc);
    chk_status("tx_status_busy", {6'b0, (n >= DEPTH), 1'b0});
    tx_hold = 1'b0;
    wait_tx(acc);
    check("tx_seen_len", tx_seen.size(), acc);
    for (int i = 0; i < exp_q.size(); i++) check("tx_byte", tx_seen[i], exp_q[i]);
    chk_counts("tx_counts_end", 0, 0);
    chk_status("tx_status_idle", 8'h04);
    $display("tx_burst n=%0d accepted=%0d seen=%0d", n, acc, tx_seen.size());
  endtask

  task automatic rx_burst(input int k);
    logic [7:0] exp_q[$]; logic [7:0] b; int held, c0; logic exp_ovr;
    tx_hold = 1'b1;
    @(negedge clk);
    c0 = n_clr;
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      rxq.push_back(b);
      if (!OVR_EN || i < DEPTH) exp_q.push_back(b);
    end
    repeat (k * 5 + 20) @(negedge clk);
    held = (k < DEPTH) ? k : DEPTH;
    exp_ovr = OVR_EN && (k > DEPTH);
    check("rx_irq", bus.irq, 1);
    chk_counts("rx_counts", held, 0);
    check("rx_clr_pulses", n_clr - c0, exp_ovr ? k - DEPTH : 0);
    chk_status("rx_status", {4'b0, exp_ovr, 3'b001});
    chk_status("rx_status_again", 8'h01);
    for (int i = 0; i < exp_q.size(); i++) cpu_pop("rx_byte", exp_q[i]);
    repeat (3) @(negedge clk);
    check("rx_irq_clear", bus.irq, 0);
    chk_counts("rx_counts_end", 0, 0);
    check("rx_uart_empty", rxq.size(), 0);
    tx_hold = 1'b0;
    $display("rx_burst k=%0d buffered=%0d read=%0d ovr=%0d", k, held, exp_q.size(), exp_ovr);
  endtask

  initial begin
    logic [15:0] d; logic ok; logic [7:0] a1, a2, a3;
    bus.cs = 1'b0; bus.addr = '0; bus.uds = 1'b0; bus.lds = 1'b0; bus.rw = 1'b1; bus.data_write = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_cpu", {bus.data_read, bus.ack, bus.irq}, 18'h0);
    check("rst_uart", {bus.u_addr, bus.u_uds, bus.u_lds, bus.u_rw, bus.u_data_write, bus.u_rx_avail_clear},
          {8'h02, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset landing in the middle of an ISSUE cycle drops the byte
    tx_hold = 1'b1;
    @(negedge clk);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, 16'hA500, d, ok);
    check("mid_push_ack", ok, 1);
    tx_hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.u_uds) begin ok = 1'b1; break; end
    end
    check("mid_issue_seen", ok, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_uart", {bus.u_addr, bus.u_uds, bus.u_rw, bus.u_data_write}, {8'h02, 1'b0, 1'b1, 16'h0});
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_counts("mid_rst_counts", 0, 0);
    check("mid_rst_dropped", tx_seen.size(), 0);
    $display("mid-ISSUE reset step done");

    // directed 0x41/0x42/0x43 under a held transmitter, then released
    tx_hold = 1'b1;
    @(negedge clk);
    tx_seen.delete();
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, 16'h4100, d, ok);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, 16'h4200, d, ok);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, 16'h4300, d, ok);
    chk_counts("abc_count3", 0, 3);
    tx_hold = 1'b0;
    wait_tx(3);
    check("abc_bytes", {tx_seen[0], tx_seen[1], tx_seen[2]}, 24'h414243);
    chk_counts("abc_count0", 0, 0);
    chk_status("abc_tx_empty", 8'h04);
    $display("ABC write step done");

    // single received byte 0x5A
    rxq.push_back(8'h5A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.irq) break;
    end
    check("rx5a_irq", bus.irq, 1);
    chk_counts("rx5a_count", 1, 0);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b1, 16'h0, d, ok);
    check("rx5a_data", {ok, d}, {1'b1, 16'h5A00});
    repeat (2) @(negedge clk);
    check("rx5a_irq_low", bus.irq, 0);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b1, 16'h0, d, ok);
    check("rx_empty_read", {ok, d}, {1'b1, 16'h0000});
    $display("0x5A receive step done");

    // decode corners: bad address unacked, reg1 write and lds write acked and ignored
    cpu_acc(8'h04, 1'b1, 1'b1, 1'b1, 16'h0, d, ok);
    check("bad_addr_noack", ok, 0);
    cpu_acc(8'h02, 1'b1, 1'b1, 1'b0, 16'hFFFF, d, ok);
    check("reg1_wr_ack", ok, 1);
    tx_seen.delete();
    cpu_acc(8'h00, 1'b0, 1'b1, 1'b0, 16'h00AA, d, ok);
    check("lds_wr_ack", ok, 1);
    repeat (10) @(negedge clk);
    check("lds_wr_nopush", tx_seen.size(), 0);
    chk_counts("decode_counts", 0, 0);

    // 17 pushes with a busy transmitter
    tx_burst(17);

    // RX and TX both pending in the same IDLE clk: RX goes first
    tx_hold = 1'b1;
    @(negedge clk);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b0, 16'h7700, d, ok);
    ops.delete(); tx_seen.delete();
    rxq.push_back(8'h33);
    tx_hold = 1'b0;
    wait_tx(1);
    check("prio_nops", ops.size(), 2);
    check("prio_order", {ops[0], ops[1]}, {8'h52, 8'h57});
    cpu_pop("prio_rx", 8'h33);
    $display("RX priority step done");

    // CPU pop lands on the engine's push edge: count stays put
    a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
    rxq.push_back(a1); rxq.push_back(a2);
    repeat (20) @(negedge clk);
    chk_counts("same_pre", 2, 0);
    rxq.push_back(a3);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.u_uds && bus.u_rw) begin ok = 1'b1; break; end
    end
    check("same_issue_seen", ok, 1);
    @(posedge clk);
    @(negedge clk);
    cpu_acc(8'h00, 1'b1, 1'b0, 1'b1, 16'h0, d, ok);
    check("same_pop_data", {ok, d}, {1'b1, a1, 8'h00});
    chk_counts("same_count", 2, 0);
    cpu_pop("same_b2", a2);
    cpu_pop("same_b3", a3);
    $display("same-clk pop/push step done");

    // RX overfill by two bytes (overrun path when enabled)
    rx_burst(18);

    for (int it = 0; it < 4; it++) begin
      tx_burst(int'($urandom_range(20, 1)));
      rx_burst(int'($urandom_range(20, 1)));
    end

    check("uart_uds_single_clk", n_dbl, 0);
    check("uart_wr_while_busy", n_busy_wr, 0);
    check("uart_lds_zero", n_lds, 0);
    check("clr_single_clk", n_clr_dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
